id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Decode-and-issue stage that sits directly upstream of the integer ALU. It decodes a 32-bit MIPS instruction into the ALU op_code/shamt encoding (0..12) and selects operands, forwarding from the EX and MEM stages. It detects load-use hazards and registers everything into the ID/EX pipeline register, whose outputs drive the ALU inputs directly. Supports stall, flush and bubble insertion.

Parameters:
DW, 32, datapath width (fixed at 32; other values unsupported)
NOP_OP, 12, op_code emitted for bubbles and illegal instructions

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction from IF/ID
instr_valid  in  1  instr is valid this cycle
rs_data  in  32  regfile read port A (instr[25:21]); regfile is write-first
rt_data  in  32  regfile read port B (instr[20:16])
stall  in  1  downstream hold; all ID/EX registers keep their values
flush  in  1  branch/jump squash; load a bubble
ex_result  in  32  ALU result of the instruction currently held in ID/EX
mem_wr_en  in  1  MEM-stage instruction writes a register
mem_rd  in  5  MEM-stage destination
mem_result  in  32  MEM-stage writeback value
reg1  out  32  ALU operand 1
reg2  out  32  ALU operand 2
op_code  out  5  ALU operation
shamt  out  5  shift amount
rd_out  out  5  destination register
reg_write  out  1  destination write enable
mem_read  out  1  lw in EX
mem_write  out  1  sw in EX
store_data  out  32  forwarded rt value for sw
valid_out  out  1  ID/EX holds a real instruction
illegal  out  1  one-cycle pulse: unsupported opcode/funct was issued
load_use_stall  out  1  combinational; IF/ID must hold instr

Behaviour:
- All outputs except load_use_stall are registered. Reset (async, rst_n=0) sets all of them to 0, except op_code=12.
- Latency: 1 cycle from instr to ALU inputs.
- R-type (opcode 0), funct -> op: 0x20->0, 0x21->1, 0x22->2, 0x23->3, 0x24->4, 0x25->5, 0x27->6, 0x2A->7, 0x00->8, 0x02->9, 0x03->10, 0x08->11.
  - instr==0 -> nop (op 12, valid_out=1, reg_write=0).
  - reg1=fwd(rs), reg2=fwd(rt), shamt=instr[10:6] (0 for non-shifts), dest=rd.
  - jr: reg_write=0.
- I-type, opcode -> op: addi 0x08->0 (sign-extended imm), addiu 0x09->1 (sign-extended), andi 0x0C->4 (zero-extended), ori 0x0D->5 (zero-extended), slti 0x0A->7 (sign-extended).
  - reg1=fwd(rs), reg2=ext(imm), dest=rt.
- lw 0x23: op 1, reg1=fwd(rs), reg2=sext(imm), mem_read=1, dest=rt.
- sw 0x2B: op 1, mem_write=1, reg_write=0, store_data=fwd(rt).
- Unsupported opcode/funct: op 12, all write/mem enables 0, valid_out=1, illegal=1 for one cycle.
- reg_write is forced to 0 whenever dest=0.
- Forwarding fwd(r):
  - r==0 -> 0.
  - Else EX match (valid_out & reg_write & !mem_read & rd_out==r) -> ex_result.
  - Else MEM match (mem_wr_en & mem_rd==r) -> mem_result.
  - Else regfile data.
  - EX has priority over MEM.
- load_use_stall = instr_valid & valid_out & mem_read & rd_out!=0 & (rd_out==rs, when rs is a source, or rd_out==rt, when rt is a source: R-type non-shift rt, shifts rt, sw).
- Next-state priority per edge:
  1. flush -> bubble (valid_out=0, op 12, all enables 0, reg1/reg2/store_data unchanged).
  2. stall -> hold all registers, illegal=0.
  3. load_use_stall -> bubble.
  4. !instr_valid -> bubble.
  5. Otherwise load decoded instruction.
- flush during stall: flush wins. load_use_stall is not suppressed by stall; IF/ID holds either way.
- Reset mid-operation: immediate return to reset values, independent of clk.

Test Plan:
- Reset: rst_n=0 mid-cycle -> outputs clear asynchronously, op_code=12, valid_out=0.
- instr=0x00221820 (add $3,$1,$2), rs_data=5, rt_data=7 -> next cycle reg1=5, reg2=7, op_code=0, rd_out=3, reg_write=1.
- instr=0x2007FFFC (addi $7,$0,-4) -> reg1=0, reg2=0xFFFFFFFC, op_code=0, rd_out=7.
- instr=0x000230C3 (sra $6,$2,3), rt_data=0x80000000 -> op_code=10, shamt=3, reg2=0x80000000.
- Load-use: 0x8C240008 (lw $4,8($1)) then 0x00842821 (addu $5,$4,$4) -> load_use_stall=1 for 1 cycle, one bubble (op 12), then addu issues with mem_result forwarded (mem_wr_en=1, mem_rd=4, mem_result=0x1234 -> reg1=reg2=0x1234).
- EX forwarding: add $3 followed by sub using $3 with ex_result=0xAA -> reg1=0xAA. Same case with flush=1 and stall=1 together -> bubble, valid_out=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS decode/issue stage feeding the integer ALU.
// It decodes instr into an ALU op_code/shamt, selects operands with EX/MEM
// forwarding, detects load-use hazards and registers the result in ID/EX.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   instr, instr_valid            instruction from IF/ID
//   rs_data, rt_data              regfile read data for instr[25:21]/[20:16]
//   stall, flush                  hold ID/EX / squash into a bubble
//   ex_result                     ALU result of the instruction held in ID/EX
//   mem_wr_en, mem_rd, mem_result MEM-stage writeback
//   reg1, reg2, op_code, shamt    ALU inputs
//   rd_out, reg_write             destination and its write enable
//   mem_read, mem_write           lw / sw in EX
//   store_data                    forwarded rt value for sw
//   valid_out, illegal            real instruction / unsupported-op pulse
//   load_use_stall                combinational; IF/ID must hold instr
module id_ex_stage #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NOP_OP = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   instr,
  input  logic          instr_valid,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic          stall,
  input  logic          flush,
  input  logic [DW-1:0] ex_result,
  input  logic          mem_wr_en,
  input  logic [4:0]    mem_rd,
  input  logic [DW-1:0] mem_result,
  output logic [DW-1:0] reg1,
  output logic [DW-1:0] reg2,
  output logic [4:0]    op_code,
  output logic [4:0]    shamt,
  output logic [4:0]    rd_out,
  output logic          reg_write,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] store_data,
  output logic          valid_out,
  output logic          illegal,
  output logic          load_use_stall
);

  localparam int unsigned RW = 5;
  localparam logic [RW-1:0] OP_NOP = RW'(NOP_OP);

  typedef struct packed {
    logic [RW-1:0] op;
    logic [RW-1:0] shamt;
    logic [RW-1:0] dest;
    logic          wr;
    logic          mrd;
    logic          mwr;
    logic          ill;
    logic          use_imm;
    logic          zext;
    logic          rs_src;
    logic          rt_src;
  } dec_t;

  logic [5:0]    opc;
  logic [5:0]    funct;
  logic [RW-1:0] rs;
  logic [RW-1:0] rt;
  logic [RW-1:0] rd;
  logic [15:0]   imm;
  dec_t          dec;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic          ex_fwd_en;
  logic          bubble;

  assign opc   = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  // Instruction decode; anything not matched stays a NOP-coded illegal op.
  always_comb begin
    dec    = '0;
    dec.op = OP_NOP;
    if (instr == 32'd0) begin
      dec.op = OP_NOP;
    end else begin
      case (opc)
        6'h00: begin
          dec.dest   = rd;
          dec.wr     = 1'b1;
          dec.rs_src = 1'b1;
          dec.rt_src = 1'b1;
          case (funct)
            6'h20: dec.op = RW'(0);
            6'h21: dec.op = RW'(1);
            6'h22: dec.op = RW'(2);
            6'h23: dec.op = RW'(3);
            6'h24: dec.op = RW'(4);
            6'h25: dec.op = RW'(5);
            6'h27: dec.op = RW'(6);
            6'h2A: dec.op = RW'(7);
            6'h00: begin dec.op = RW'(8);  dec.shamt = instr[10:6]; dec.rs_src = 1'b0; end
            6'h02: begin dec.op = RW'(9);  dec.shamt = instr[10:6]; dec.rs_src = 1'b0; end
            6'h03: begin dec.op = RW'(10); dec.shamt = instr[10:6]; dec.rs_src = 1'b0; end
            6'h08: begin dec.op = RW'(11); dec.wr = 1'b0; end
            default: begin
              dec.ill    = 1'b1;
              dec.dest   = '0;
              dec.wr     = 1'b0;
              dec.rs_src = 1'b0;
              dec.rt_src = 1'b0;
            end
          endcase
        end
        6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h23: begin
          dec.dest    = rt;
          dec.wr      = 1'b1;
          dec.use_imm = 1'b1;
          dec.rs_src  = 1'b1;
          case (opc)
            6'h08:   dec.op = RW'(0);
            6'h09:   dec.op = RW'(1);
            6'h0A:   dec.op = RW'(7);
            6'h0C:   begin dec.op = RW'(4); dec.zext = 1'b1; end
            6'h0D:   begin dec.op = RW'(5); dec.zext = 1'b1; end
            default: begin dec.op = RW'(1); dec.mrd = 1'b1; end
          endcase
        end
        6'h2B: begin
          dec.op      = RW'(1);
          dec.mwr     = 1'b1;
          dec.use_imm = 1'b1;
          dec.rs_src  = 1'b1;
          dec.rt_src  = 1'b1;
        end
        default: dec.ill = 1'b1;
      endcase
    end
  end

  assign imm_ext = dec.zext ? DW'({16'd0, imm}) : DW'({{16{imm[15]}}, imm});

  // A load in EX has no result yet; it is covered by load_use_stall instead.
  assign ex_fwd_en = valid_out & reg_write & ~mem_read;

  // Operand forwarding: EX beats MEM beats the regfile; $0 always reads zero.
  assign fwd_rs = (rs == '0)                          ? '0 :
                  (ex_fwd_en && (rd_out == rs))       ? ex_result :
                  (mem_wr_en && (mem_rd == rs))       ? mem_result : rs_data;
  assign fwd_rt = (rt == '0)                          ? '0 :
                  (ex_fwd_en && (rd_out == rt))       ? ex_result :
                  (mem_wr_en && (mem_rd == rt))       ? mem_result : rt_data;

  assign load_use_stall = instr_valid & valid_out & mem_read & (rd_out != '0) &
                          ((dec.rs_src & (rd_out == rs)) | (dec.rt_src & (rd_out == rt)));

  // flush wins over stall; stall wins over the hazard/empty-slot bubbles.
  assign bubble = flush | (~stall & (load_use_stall | ~instr_valid));

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg1       <= '0;
      reg2       <= '0;
      op_code    <= OP_NOP;
      shamt      <= '0;
      rd_out     <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      store_data <= '0;
      valid_out  <= 1'b0;
      illegal    <= 1'b0;
    end else if (bubble) begin
      op_code    <= OP_NOP;
      shamt      <= '0;
      rd_out     <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      valid_out  <= 1'b0;
      illegal    <= 1'b0;
    end else if (stall) begin
      illegal    <= 1'b0;
    end else begin
      reg1       <= fwd_rs;
      reg2       <= dec.use_imm ? imm_ext : fwd_rt;
      op_code    <= dec.op;
      shamt      <= dec.shamt;
      rd_out     <= dec.dest;
      reg_write  <= dec.wr & (dec.dest != '0);
      mem_read   <= dec.mrd;
      mem_write  <= dec.mwr;
      store_data <= fwd_rt;
      valid_out  <= 1'b1;
      illegal    <= dec.ill;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors with literal expectations plus a
// behavioural model compared against every output on each falling edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ex_result = '0;
  logic        mem_wr_en = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_result = '0;
  logic [31:0] reg1, reg2, store_data;
  logic [4:0]  op_code, shamt, rd_out;
  logic        reg_write, mem_read, mem_write, valid_out, illegal, load_use_stall;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DW(32), .NOP_OP(12)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
    .ex_result(ex_result), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd),
    .mem_result(mem_result), .reg1(reg1), .reg2(reg2), .op_code(op_code),
    .shamt(shamt), .rd_out(rd_out), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .store_data(store_data), .valid_out(valid_out),
    .illegal(illegal), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] reg1, reg2, store;
    logic [4:0]  op, shamt, rd;
    logic        rw, mr, mw, valid, ill;
  } exp_t;

  exp_t e;
  int rop [64];
  int iop [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mfwd(input int r, input logic [31:0] rf);
    if (r == 0) return 32'd0;
    if (e.valid && e.rw && !e.mr && int'(e.rd) == r) return ex_result;
    if (mem_wr_en && int'(mem_rd) == r) return mem_result;
    return rf;
  endfunction

  function automatic logic model_lus();
    int o = int'(instr[31:26]);
    int f = int'(instr[5:0]);
    int rs = int'(instr[25:21]);
    int rt = int'(instr[20:16]);
    logic legal_r = (o == 0) && (instr != 32'd0) && (rop[f] >= 0);
    logic shift   = legal_r && (f == 0 || f == 2 || f == 3);
    logic rs_used = (legal_r && !shift) || (iop[o] >= 0) || (o == 'h2B);
    logic rt_used = legal_r || (o == 'h2B);
    return instr_valid && e.valid && e.mr && e.rd != 0 &&
           ((rs_used && int'(e.rd) == rs) || (rt_used && int'(e.rd) == rt));
  endfunction

  function automatic exp_t issue();
    exp_t n;
    int o = int'(instr[31:26]);
    int f = int'(instr[5:0]);
    logic [31:0] sx = {{16{instr[15]}}, instr[15:0]};
    logic [31:0] zx = {16'd0, instr[15:0]};
    n.reg1 = mfwd(int'(instr[25:21]), rs_data);
    n.reg2 = mfwd(int'(instr[20:16]), rt_data);
    n.store = n.reg2;
    n.valid = 1; n.op = 5'd12; n.shamt = 0; n.rd = 0;
    n.rw = 0; n.mr = 0; n.mw = 0; n.ill = 0;
    if (instr == 32'd0) begin
      n.op = 5'd12;
    end else if (o == 0 && rop[f] >= 0) begin
      n.op = 5'(rop[f]);
      n.rd = instr[15:11];
      n.rw = (f != 'h08);
      if (f == 0 || f == 2 || f == 3) n.shamt = instr[10:6];
    end else if (iop[o] >= 0) begin
      n.op = 5'(iop[o]);
      n.rd = instr[20:16];
      n.rw = 1;
      n.reg2 = (o == 'h0C || o == 'h0D) ? zx : sx;
      n.mr = (o == 'h23);
    end else if (o == 'h2B) begin
      n.op = 5'd1; n.mw = 1; n.reg2 = sx;
    end else begin
      n.ill = 1;
    end
    if (n.rd == 0) n.rw = 0;
    return n;
  endfunction

  function automatic exp_t next_exp();
    exp_t n = e;
    if (flush || (!stall && (model_lus() || !instr_valid))) begin
      n.valid = 0; n.op = 5'd12; n.shamt = 0; n.rd = 0;
      n.rw = 0; n.mr = 0; n.mw = 0; n.ill = 0;
    end else if (stall) begin
      n.ill = 0;
    end else begin
      n = issue();
    end
    return n;
  endfunction

  // Model state update.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      e.reg1 = 0; e.reg2 = 0; e.store = 0; e.op = 5'd12; e.shamt = 0; e.rd = 0;
      e.rw = 0; e.mr = 0; e.mw = 0; e.valid = 0; e.ill = 0;
    end else begin
      e = next_exp();
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    chk("m_reg1", reg1, e.reg1);
    chk("m_reg2", reg2, e.reg2);
    chk("m_op", 32'(op_code), 32'(e.op));
    chk("m_shamt", 32'(shamt), 32'(e.shamt));
    chk("m_rd", 32'(rd_out), 32'(e.rd));
    chk("m_reg_write", 32'(reg_write), 32'(e.rw));
    chk("m_mem_read", 32'(mem_read), 32'(e.mr));
    chk("m_mem_write", 32'(mem_write), 32'(e.mw));
    chk("m_valid", 32'(valid_out), 32'(e.valid));
    chk("m_illegal", 32'(illegal), 32'(e.ill));
    if (valid_out && mem_write) chk("m_store", store_data, e.store);
    chk("m_lus", 32'(load_use_stall), 32'(rst_n ? model_lus() : 1'b0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin rop[i] = -1; iop[i] = -1; end
    rop['h20] = 0; rop['h21] = 1; rop['h22] = 2; rop['h23] = 3; rop['h24] = 4;
    rop['h25] = 5; rop['h27] = 6; rop['h2A] = 7; rop['h00] = 8; rop['h02] = 9;
    rop['h03] = 10; rop['h08] = 11;
    iop['h08] = 0; iop['h09] = 1; iop['h0C] = 4; iop['h0D] = 5; iop['h0A] = 7; iop['h23] = 1;

    repeat (2) tick();
    chk("rst_op", 32'(op_code), 32'd12);
    chk("rst_valid", 32'(valid_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // add $3,$1,$2
    instr = 32'h00221820; instr_valid = 1; rs_data = 5; rt_data = 7;
    tick();
    chk("add_reg1", reg1, 32'd5);
    chk("add_reg2", reg2, 32'd7);
    chk("add_op", 32'(op_code), 32'd0);
    chk("add_rd", 32'(rd_out), 32'd3);
    chk("add_rw", 32'(reg_write), 32'd1);

    // addi $7,$0,-4
    instr = 32'h2007FFFC; rs_data = 32'h99; rt_data = 0;
    tick();
    chk("addi_reg1", reg1, 32'd0);
    chk("addi_reg2", reg2, 32'hFFFFFFFC);
    chk("addi_op", 32'(op_code), 32'd0);
    chk("addi_rd", 32'(rd_out), 32'd7);

    // sra $6,$2,3
    instr = 32'h000230C3; rs_data = 0; rt_data = 32'h80000000;
    tick();
    chk("sra_op", 32'(op_code), 32'd10);
    chk("sra_shamt", 32'(shamt), 32'd3);
    chk("sra_reg2", reg2, 32'h80000000);

    // lw $4,8($1) followed by dependent addu $5,$4,$4
    instr = 32'h8C240008; rs_data = 32'h100; rt_data = 0;
    tick();
    chk("lw_op", 32'(op_code), 32'd1);
    chk("lw_mem_read", 32'(mem_read), 32'd1);
    chk("lw_reg1", reg1, 32'h100);
    chk("lw_reg2", reg2, 32'd8);
    instr = 32'h00842821; rs_data = 32'h55; rt_data = 32'h55;
    #1 chk("lu_stall_on", 32'(load_use_stall), 32'd1);
    tick();
    chk("lu_bubble_op", 32'(op_code), 32'd12);
    chk("lu_bubble_valid", 32'(valid_out), 32'd0);
    mem_wr_en = 1; mem_rd = 5'd4; mem_result = 32'h1234;
    #1 chk("lu_stall_off", 32'(load_use_stall), 32'd0);
    tick();
    chk("addu_op", 32'(op_code), 32'd1);
    chk("addu_reg1", reg1, 32'h1234);
    chk("addu_reg2", reg2, 32'h1234);
    chk("addu_rd", 32'(rd_out), 32'd5);
    mem_wr_en = 0;

    // add $3 then sub $4,$3,$1: EX forward beats a MEM match on $3
    instr = 32'h00221820; rs_data = 5; rt_data = 7;
    tick();
    instr = 32'h00612022; rs_data = 32'h11; rt_data = 32'h22; ex_result = 32'hAA;
    mem_wr_en = 1; mem_rd = 5'd3; mem_result = 32'hBB;
    tick();
    chk("sub_reg1", reg1, 32'hAA);
    chk("sub_reg2", reg2, 32'h22);
    chk("sub_op", 32'(op_code), 32'd2);
    mem_wr_en = 0;

    // flush together with stall -> bubble, operands kept
    instr = 32'h00221820; flush = 1; stall = 1;
    tick();
    chk("fs_valid", 32'(valid_out), 32'd0);
    chk("fs_op", 32'(op_code), 32'd12);
    chk("fs_reg1", reg1, 32'hAA);
    flush = 0; stall = 0;

    // andi $8,$1,0x8000 (zero-extended), then stall holds it
    instr = 32'h30288000; rs_data = 32'hFFFFFFFF;
    tick();
    chk("andi_reg2", reg2, 32'h00008000);
    chk("andi_op", 32'(op_code), 32'd4);
    stall = 1; instr = 32'hAC220004;
    tick();
    chk("stall_op", 32'(op_code), 32'd4);
    chk("stall_rd", 32'(rd_out), 32'd8);
    stall = 0;

    // sw $2,4($1)
    rs_data = 32'h200; rt_data = 32'hDEAD;
    tick();
    chk("sw_mem_write", 32'(mem_write), 32'd1);
    chk("sw_rw", 32'(reg_write), 32'd0);
    chk("sw_store", store_data, 32'hDEAD);
    chk("sw_reg2", reg2, 32'd4);

    // unsupported opcode pulses illegal for one cycle
    instr = 32'hFC000000;
    tick();
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_op", 32'(op_code), 32'd12);
    chk("ill_valid", 32'(valid_out), 32'd1);
    instr_valid = 0;
    tick();
    chk("ill_clear", 32'(illegal), 32'd0);
    chk("idle_valid", 32'(valid_out), 32'd0);

    // instr==0 is a real nop; add $0 never writes
    instr = 32'h0; instr_valid = 1;
    tick();
    chk("nop_valid", 32'(valid_out), 32'd1);
    chk("nop_op", 32'(op_code), 32'd12);
    instr = 32'h00220020; rs_data = 1; rt_data = 2;
    tick();
    chk("rd0_rw", 32'(reg_write), 32'd0);
    chk("rd0_op", 32'(op_code), 32'd0);

    // mid-cycle asynchronous reset
    instr = 32'h00221820; rs_data = 5; rt_data = 7;
    tick();
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(valid_out), 32'd0);
    chk("arst_op", 32'(op_code), 32'd12);
    chk("arst_reg1", reg1, 32'd0);
    tick();
    rst_n = 1;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
